fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter N, default 64, PC and branch-target width in bits.
REQ-002 SHALL have parameter AW, default 6, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  decode not ready; hold PC and the IF/ID register.
REQ-006 SHALL have port br_taken  input  1  redirect request from a later stage.
REQ-007 SHALL have port br_target  input  N  redirect byte address.
REQ-008 SHALL have port imem_addr  output  AW  word address to the instruction ROM.
REQ-009 SHALL have port imem_q  input  32  combinational ROM read data for imem_addr.
REQ-010 SHALL have port instr_d  output  32  IF/ID instruction.
REQ-011 SHALL have port pc_d  output  N  IF/ID PC of instr_d.
REQ-012 SHALL have port valid_d  output  1  instr_d/pc_d hold a real instruction.
REQ-013 SHALL have port halted  output  1  fetch stopped on an all-zero word.
REQ-014 SHALL have port fetch_cnt  output  32  count of instructions delivered to IF/ID.

Function
REQ-015 SHALL drive imem_addr = pc[AW+1:2] combinationally; upper PC bits don't affect the address (wraps every 4*2^AW bytes).
REQ-016 SHALL compute next PC with priority: br_taken -> {br_target[N-1:2],2'b00}; else stall or HALT -> hold; else pc+4 (modulo 2^N).
REQ-017 SHALL implement FSM states RUN and HALT, with halted = (state==HALT).
REQ-018 SHALL go RUN->HALT when in RUN, br_taken=0, stall=0 and imem_q==32'h0; the zero word is not delivered and PC holds.
REQ-019 SHALL go HALT->RUN only on br_taken=1, loading the target PC as in REQ-016.
REQ-020 SHALL, when br_taken=1 (any state, stall ignored), load IF/ID with instr_d=0, valid_d=0, and pc_d unchanged (flush/bubble).
REQ-021 SHALL otherwise, when stall=1, hold instr_d, pc_d and valid_d unchanged.
REQ-022 SHALL otherwise, in HALT or on the RUN->HALT cycle, load instr_d=0 and valid_d=0.
REQ-023 SHALL otherwise, in RUN with a nonzero word, load instr_d=imem_q, pc_d=pc, valid_d=1.
REQ-024 SHALL present the word at PC p on instr_d exactly one cycle after pc=p, so throughput is one instruction per unstalled cycle.
REQ-025 SHALL increment fetch_cnt by 1 exactly on cycles meeting REQ-023; it wraps at 2^32.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set pc=0, state=RUN, instr_d=0, pc_d=0, valid_d=0 and fetch_cnt=0, overriding br_taken and stall.
REQ-027 SHALL make the first post-reset fetch read imem_addr=0, with its word valid on instr_d one cycle after reset deasserts.
REQ-028 SHALL, on reset asserted mid-stall or in HALT, return to RUN at PC 0 regardless of pending stall.

Structure
REQ-029 SHALL place the shared package contents (fetch_state_t enum {RUN,HALT}, PC_INC=4, default N and AW, INSTR_W=32) in a package shared with the decode stage.
REQ-030 SHALL use exactly one sub-module, if_id_reg: a parameterized register with synchronous reset, enable (~stall) and clear (flush) inputs, instantiated for instr, pc and valid.
REQ-031 SHALL keep the ROM external; this block only drives imem_addr and consumes imem_q.

Verification
REQ-032 SHALL verify reset then run: ROM word k = 0x8B000000+k, no stall -> cycles 1..3 give instr_d=0x8B000000/01/02, pc_d=0/4/8, fetch_cnt=3.
REQ-033 SHALL verify stall: stall=1 for 2 cycles at pc=8 -> instr_d holds 0x8B000001, imem_addr holds 2, fetch_cnt frozen; resume -> 0x8B000002.
REQ-034 SHALL verify redirect: br_taken=1, br_target=0x16 with stall=1 at the same cycle -> next valid_d=0, pc=0x14; following cycle instr_d=word 5, pc_d=0x14.
REQ-035 SHALL verify halt: ROM word 9 = 0 -> halted=1 after fetching pc=0x24, valid_d=0 thereafter, pc stays 0x24; br_taken to 0x0 -> RUN, word 0 delivered.
REQ-036 SHALL verify wrap: pc reaching 0xFC then 0x100 -> imem_addr 63 then 0, and pc_d=0x100 carries word 0.
REQ-037 SHALL verify mid-operation reset: reset during HALT with stall=1 -> all outputs zero, halted=0, next fetch from addr 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM state type and datapath widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_stage_pkg;

  localparam int N_DEF   = 64;  // PC / branch-target width
  localparam int AW_DEF  = 6;   // instruction-memory word-address width
  localparam int INSTR_W = 32;  // instruction word width
  localparam int PC_INC  = 4;   // bytes per instruction

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register slice with synchronous reset, clear and enable.
// Latency: one cycle from d to q when enabled.
// Backpressure: en low holds q; clr wins over en so a flush lands even while stalled.
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;

  // Reset and clear both zero the slice; otherwise capture only when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives ROM address from PC, fills IF/ID, halts on an all-zero word.
// Latency: word at PC p appears on instr_d one cycle after pc==p (one instr per cycle).
// Backpressure: stall holds PC and IF/ID; br_taken overrides stall and flushes IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [N-1:0]       br_target,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  output logic [INSTR_W-1:0] instr_d,
  output logic [N-1:0]       pc_d,
  output logic               valid_d,
  output logic               halted,
  output logic [31:0]        fetch_cnt
);

  fetch_state_t state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         deliver;

  logic [INSTR_W-1:0] instr_nxt;
  logic [0:0]         valid_nxt;
  logic [0:0]         valid_out;

  // The ROM is word addressed; PC bits above the ROM size simply alias.
  assign imem_addr = fetch_pc_q[AW+1:2];

  // State, PC and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next PC / state: redirect first, then stall/halt hold, else sequential fetch.
  // A zero word in RUN halts without being delivered and without advancing PC.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    deliver    = 1'b0;
    if (br_taken) begin
      // Clear the byte-offset bits so the target is word aligned.
      fetch_pc_d = br_target & ~N'(3);
      state_d    = RUN;
    end else if (!stall && state_q == RUN) begin
      if (imem_q == '0) begin
        state_d = HALT;
      end else begin
        deliver    = 1'b1;
        fetch_pc_d = fetch_pc_q + N'(PC_INC);
      end
    end
    cnt_d = cnt_q + (deliver ? 32'd1 : 32'd0);
  end

  // Bubble (zero, invalid) unless a real word is delivered this cycle.
  assign instr_nxt = deliver ? imem_q : '0;
  assign valid_nxt = deliver;

  if_id_reg #(.W(INSTR_W)) u_instr_reg (
    .clk (clk),
    .rst (reset),
    .en  (~stall),
    .clr (br_taken),
    .d   (instr_nxt),
    .q   (instr_d)
  );

  if_id_reg #(.W(1)) u_valid_reg (
    .clk (clk),
    .rst (reset),
    .en  (~stall),
    .clr (br_taken),
    .d   (valid_nxt),
    .q   (valid_out)
  );

  // pc_d only tracks real instructions; bubbles and flushes leave it as-is.
  if_id_reg #(.W(N)) u_pc_reg (
    .clk (clk),
    .rst (reset),
    .en  (deliver),
    .clr (1'b0),
    .d   (fetch_pc_q),
    .q   (pc_d)
  );

  assign valid_d   = valid_out[0];
  assign halted    = (state_q == HALT);
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic.
// Latency: one step = one clock; outputs compared 1ns after each rising edge.
// Backpressure: stall/br_taken/reset driven directly by the bench.
module tb_fetch_stage;

  localparam int N  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          br_taken;
  logic [N-1:0]  br_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic [31:0]   instr_d;
  logic [N-1:0]  pc_d;
  logic          valid_d;
  logic          halted;
  logic [31:0]   fetch_cnt;

  logic [31:0] rom [0:63];

  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  fetch_stage #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem_addr (imem_addr),
    .imem_q    (imem_q),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .valid_d   (valid_d),
    .halted    (halted),
    .fetch_cnt (fetch_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural view of the fetch stage.
  logic [63:0] m_pc;
  logic        m_halt;
  logic [31:0] m_instr;
  logic [63:0] m_pcd;
  logic        m_valid;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, advance the model, then compare every output.
  task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t);
    logic [31:0] w;
    reset     = r;
    stall     = s;
    br_taken  = b;
    br_target = t;
    w = rom[m_pc[7:2]];
    if (r) begin
      m_pc = 0; m_halt = 0; m_instr = 0; m_pcd = 0; m_valid = 0; m_cnt = 0;
    end else if (b) begin
      m_pc = t & ~64'h3; m_halt = 0; m_instr = 0; m_valid = 0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (m_halt || w == 32'h0) begin
      m_halt = 1; m_instr = 0; m_valid = 0;
    end else begin
      m_instr = w; m_pcd = m_pc; m_valid = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    chk("model_imem_addr", imem_addr, m_pc[7:2]);
    chk("model_instr_d",   instr_d,   m_instr);
    chk("model_pc_d",      pc_d,      m_pcd);
    chk("model_valid_d",   valid_d,   m_valid);
    chk("model_halted",    halted,    m_halt);
    chk("model_fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    m_pc = 0; m_halt = 0; m_instr = 0; m_pcd = 0; m_valid = 0; m_cnt = 0;
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    for (int k = 0; k < 64; k++) rom[k] = 32'h8B000000 + k;
    rom[9] = 32'h0;

    // Reset then straight-line fetch.
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b1, 64'h40);
    chk("rst_instr", instr_d, 64'h0);
    chk("rst_valid", valid_d, 64'h0);
    chk("rst_halted", halted, 64'h0);
    chk("rst_cnt", fetch_cnt, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
    run(1);
    chk("run1_instr", instr_d, 64'h8B000000);
    chk("run1_pcd", pc_d, 64'h0);
    chk("run1_valid", valid_d, 64'h1);
    run(1);
    chk("run2_instr", instr_d, 64'h8B000001);
    chk("run2_pcd", pc_d, 64'h4);
    run(1);
    chk("run3_instr", instr_d, 64'h8B000002);
    chk("run3_pcd", pc_d, 64'h8);
    chk("run3_cnt", fetch_cnt, 64'd3);

    // Stall at pc=8.
    step(1'b1, 1'b0, 1'b0, 64'h0);
    run(2);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0);
      chk("stall_instr", instr_d, 64'h8B000001);
      chk("stall_addr", imem_addr, 64'd2);
      chk("stall_cnt", fetch_cnt, 64'd2);
    end
    run(1);
    chk("resume_instr", instr_d, 64'h8B000002);
    chk("resume_pcd", pc_d, 64'h8);

    // Redirect with a simultaneous stall.
    step(1'b0, 1'b1, 1'b1, 64'h16);
    chk("redir_valid", valid_d, 64'h0);
    chk("redir_addr", imem_addr, 64'd5);
    chk("redir_pcd_hold", pc_d, 64'h8);
    run(1);
    chk("redir_instr", instr_d, 64'h8B000005);
    chk("redir_pcd", pc_d, 64'h14);

    // Run into the zero word at 0x24.
    run(4);
    chk("halt_flag", halted, 64'h1);
    chk("halt_valid", valid_d, 64'h0);
    chk("halt_addr", imem_addr, 64'd9);
    run(3);
    chk("halt_stay", halted, 64'h1);
    chk("halt_stay_addr", imem_addr, 64'd9);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("unhalt_flag", halted, 64'h0);
    chk("unhalt_addr", imem_addr, 64'd0);
    run(1);
    chk("unhalt_instr", instr_d, 64'h8B000000);

    // Address wrap past the end of the ROM.
    step(1'b0, 1'b0, 1'b1, 64'hF8);
    run(1);
    chk("wrap_addr63", imem_addr, 64'd63);
    run(1);
    chk("wrap_addr0", imem_addr, 64'd0);
    run(1);
    chk("wrap_pcd", pc_d, 64'h100);
    chk("wrap_instr", instr_d, 64'h8B000000);

    // Reset while halted and stalled.
    step(1'b0, 1'b0, 1'b1, 64'h24);
    run(1);
    chk("pre_rst_halt", halted, 64'h1);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("mrst_halted", halted, 64'h0);
    chk("mrst_instr", instr_d, 64'h0);
    chk("mrst_pcd", pc_d, 64'h0);
    chk("mrst_cnt", fetch_cnt, 64'h0);
    chk("mrst_addr", imem_addr, 64'h0);
    run(1);
    chk("mrst_first", instr_d, 64'h8B000000);

    // Randomized traffic against the model.
    for (int k = 0; k < 64; k++)
      rom[k] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom() | 32'h1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           {$urandom(), $urandom()});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
